// File: rtl/fsk_modulator_if.sv
// Serial-bit input and waveform output bundle of the FSK modulator.
// master drives valid/bit_in from the message controller; slave is the modulator side.
interface fsk_modulator_if #(
  parameter int OUT_W = 8
);
  logic             valid;
  logic             bit_in;
  logic [OUT_W-1:0] fsk_out;
  logic             busy;
  logic             phase_wrap;

  modport master (
    output valid,
    output bit_in,
    input  fsk_out,
    input  busy,
    input  phase_wrap
  );

  modport slave (
    input  valid,
    input  bit_in,
    output fsk_out,
    output busy,
    output phase_wrap
  );
endinterface

// File: rtl/fsk_modulator.sv
// Binary FSK modulator: phase-continuous triangle wave, step INC0/INC1 per serial bit.
// fsk_out follows the phase register with zero latency; no backpressure, a dropped valid drains to phase 0.
module fsk_modulator #(
  parameter int PHASE_W = 10,
  parameter int OUT_W   = 8,
  parameter int INC0    = 4,
  parameter int INC1    = 8
) (
  input  logic           clk,
  input  logic           reset,
  fsk_modulator_if.slave bus
);

  localparam logic [PHASE_W-1:0] STEP0 = PHASE_W'(INC0);
  localparam logic [PHASE_W-1:0] STEP1 = PHASE_W'(INC1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_nxt;
  logic [PHASE_W-1:0] inc;
  logic [PHASE_W:0]   sum;
  logic               ovf;
  logic               sel_bit;
  logic               last_bit;
  logic               wrap_nxt;
  logic               busy_q;
  logic               wrap_q;
  logic [OUT_W-1:0]   tri_t;
  logic [OUT_W-1:0]   fsk_dat;

  // Once valid drops, the step keeps following the last bit seen.
  always_comb begin
    sel_bit = bus.valid ? bus.bit_in : last_bit;
    inc     = sel_bit ? STEP1 : STEP0;
    sum     = {1'b0, phase} + {1'b0, inc};
    ovf     = sum[PHASE_W];
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    wrap_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.valid) begin
          state_nxt = RUN;
          phase_nxt = inc;
        end else begin
          phase_nxt = '0;
        end
      end
      RUN: begin
        phase_nxt = sum[PHASE_W-1:0];
        wrap_nxt  = ovf;
        if (!bus.valid) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        wrap_nxt = ovf;
        if (bus.valid) begin
          // Re-arm keeps the remainder so the tone stays phase-continuous.
          state_nxt = RUN;
          phase_nxt = sum[PHASE_W-1:0];
        end else if (ovf) begin
          state_nxt = IDLE;
          phase_nxt = '0;
        end else begin
          phase_nxt = sum[PHASE_W-1:0];
        end
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      phase    <= '0;
      last_bit <= 1'b0;
      busy_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      phase  <= phase_nxt;
      busy_q <= (state_nxt != IDLE);
      wrap_q <= wrap_nxt;
      if (bus.valid) begin
        last_bit <= bus.bit_in;
      end
    end
  end

  // Top phase bit selects the falling half of the triangle.
  always_comb begin
    tri_t   = phase[PHASE_W-2 -: OUT_W];
    fsk_dat = phase[PHASE_W-1] ? ~tri_t : tri_t;
  end

  assign bus.fsk_out    = fsk_dat;
  assign bus.busy       = busy_q;
  assign bus.phase_wrap = wrap_q;

endmodule

// File: tb/tb_fsk_modulator.sv
// Self-checking bench for fsk_modulator against a cycle-level arithmetic phase model.
module tb_fsk_modulator;

  localparam int PHASE_W = 10;
  localparam int OUT_W   = 8;
  localparam int INC0    = 4;
  localparam int INC1    = 8;
  localparam int PH_MOD  = 1 << PHASE_W;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  fsk_modulator_if #(.OUT_W(OUT_W)) bus ();

  fsk_modulator #(
    .PHASE_W(PHASE_W),
    .OUT_W  (OUT_W),
    .INC0   (INC0),
    .INC1   (INC1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase as a plain integer, plus "producing a tone" and "draining" flags.
  int m_phase;
  bit m_active;
  bit m_drain;
  bit m_last;
  bit m_wrap;

  function automatic int wave(input int p);
    return (p < PH_MOD / 2) ? p / 2 : (PH_MOD - 1 - p) / 2;
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_active = 0;
    m_drain  = 0;
    m_last   = 0;
    m_wrap   = 0;
  endtask

  task automatic model_step(input bit v, input bit b);
    int inc;
    int s;
    inc = (v ? b : m_last) ? INC1 : INC0;
    if (!m_active) begin
      m_wrap = 0;
      if (v) begin
        m_phase  = inc;
        m_active = 1;
        m_drain  = 0;
      end
    end else begin
      s      = m_phase + inc;
      m_wrap = (s >= PH_MOD);
      if (v) begin
        m_phase = s % PH_MOD;
        m_drain = 0;
      end else if (m_drain && s >= PH_MOD) begin
        m_phase  = 0;
        m_active = 0;
        m_drain  = 0;
      end else begin
        m_phase = s % PH_MOD;
        m_drain = 1;
      end
    end
    if (v) m_last = b;
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic tick(input bit v, input bit b);
    bus.valid  = v;
    bus.bit_in = b;
    @(posedge clk);
    model_step(v, b);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    bus.valid  = 1'b0;
    bus.bit_in = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 40; i++) tick(1'b1, 1'($urandom));
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if ({bus.fsk_out, bus.busy, bus.phase_wrap} !== {8'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_async: got fsk=%0d busy=%0b wrap=%0b want 0/0/0",
               bus.fsk_out, bus.busy, bus.phase_wrap);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'($urandom));
      n_cmp++;
      if ({bus.fsk_out, bus.busy, bus.phase_wrap} !== {8'd0, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL reset_idle[%0d]: got fsk=%0d busy=%0b wrap=%0b want 0/0/0",
                 i, bus.fsk_out, bus.busy, bus.phase_wrap);
      end
    end
  endtask

  task automatic test_start_latency();
    do_reset();
    tick(1'b1, 1'b0);
    n_cmp++;
    if ({bus.fsk_out, bus.busy, bus.phase_wrap} !== {8'd2, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL start_k: got fsk=%0d busy=%0b wrap=%0b want 2/1/0",
               bus.fsk_out, bus.busy, bus.phase_wrap);
    end
    tick(1'b1, 1'b0);
    n_cmp++;
    if ({bus.fsk_out, bus.busy} !== {8'd4, 1'b1}) begin
      n_bad++;
      $display("FAIL start_k1: got fsk=%0d busy=%0b want 4/1", bus.fsk_out, bus.busy);
    end
  endtask

  task automatic test_bit1_tone();
    int max_out;
    int wraps;
    do_reset();
    max_out = 0;
    wraps   = 0;
    for (int k = 1; k <= 384; k++) begin
      tick(1'b1, 1'b1);
      if (int'(bus.fsk_out) > max_out) max_out = int'(bus.fsk_out);
      if (bus.phase_wrap) wraps++;
      n_cmp++;
      if (bus.phase_wrap !== ((k % 128) == 0)) begin
        n_bad++;
        $display("FAIL tone1_wrap[%0d]: got %0b want %0b", k, bus.phase_wrap, (k % 128) == 0);
      end
      n_cmp++;
      if ({bus.fsk_out, bus.busy} !== {8'(wave(m_phase)), m_active}) begin
        n_bad++;
        $display("FAIL tone1_wave[%0d]: got fsk=%0d busy=%0b want %0d/%0b",
                 k, bus.fsk_out, bus.busy, wave(m_phase), m_active);
      end
    end
    n_cmp++;
    if (max_out !== 255 || wraps !== 3) begin
      n_bad++;
      $display("FAIL tone1_peak: got max=%0d wraps=%0d want 255/3", max_out, wraps);
    end
  endtask

  task automatic test_tone_switch();
    int prev;
    int d;
    do_reset();
    for (int i = 0; i < 75; i++) tick(1'b1, 1'b0);
    prev = int'(bus.fsk_out);
    tick(1'b1, 1'b1);
    n_cmp++;
    if (bus.fsk_out !== 8'(wave(308))) begin
      n_bad++;
      $display("FAIL switch_step: got fsk=%0d want %0d", bus.fsk_out, wave(308));
    end
    for (int i = 0; i < 200; i++) begin
      prev = int'(bus.fsk_out);
      tick(1'b1, (i % 50) < 30);
      d = int'(bus.fsk_out) - prev;
      if (d < 0) d = -d;
      n_cmp++;
      if (d > 4 || bus.fsk_out !== 8'(wave(m_phase))) begin
        n_bad++;
        $display("FAIL switch_cont[%0d]: got fsk=%0d prev=%0d want %0d step<=4",
                 i, bus.fsk_out, prev, wave(m_phase));
      end
    end
  endtask

  task automatic test_drain();
    do_reset();
    for (int i = 0; i < 25; i++) tick(1'b1, 1'b0);
    for (int e = 1; e <= 231; e++) begin
      tick(1'b0, 1'($urandom));
      n_cmp++;
      if ({bus.fsk_out, bus.busy, bus.phase_wrap} !==
          {8'(wave(m_phase)), (e != 231), (e == 231)}) begin
        n_bad++;
        $display("FAIL drain[%0d]: got fsk=%0d busy=%0b wrap=%0b want %0d/%0b/%0b",
                 e, bus.fsk_out, bus.busy, bus.phase_wrap, wave(m_phase), e != 231, e == 231);
      end
    end
    tick(1'b0, 1'b1);
    n_cmp++;
    if ({bus.fsk_out, bus.busy, bus.phase_wrap} !== {8'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL drain_idle: got fsk=%0d busy=%0b wrap=%0b want 0/0/0",
               bus.fsk_out, bus.busy, bus.phase_wrap);
    end
  endtask

  task automatic test_rearm();
    int busy_drops;
    do_reset();
    busy_drops = 0;
    for (int i = 0; i < 25; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 125; i++) begin
      tick(1'b0, 1'b1);
      if (!bus.busy) busy_drops++;
    end
    n_cmp++;
    if (bus.fsk_out !== 8'(wave(600))) begin
      n_bad++;
      $display("FAIL rearm_at600: got fsk=%0d want %0d", bus.fsk_out, wave(600));
    end
    tick(1'b1, 1'b0);
    n_cmp++;
    if ({bus.fsk_out, bus.busy} !== {8'(wave(604)), 1'b1}) begin
      n_bad++;
      $display("FAIL rearm_604: got fsk=%0d busy=%0b want %0d/1", bus.fsk_out, bus.busy, wave(604));
    end
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0);
      if (!bus.busy) busy_drops++;
    end
    n_cmp++;
    if (busy_drops !== 0) begin
      n_bad++;
      $display("FAIL rearm_busy: got %0d busy drops want 0", busy_drops);
    end
  endtask

  task automatic test_random();
    bit v;
    do_reset();
    v = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 40) == 0) v = ~v;
      tick(v, 1'($urandom));
      n_cmp++;
      if ({bus.fsk_out, bus.busy, bus.phase_wrap} !== {8'(wave(m_phase)), m_active, m_wrap}) begin
        n_bad++;
        $display("FAIL random[%0d]: got fsk=%0d busy=%0b wrap=%0b want %0d/%0b/%0b",
                 i, bus.fsk_out, bus.busy, bus.phase_wrap, wave(m_phase), m_active, m_wrap);
      end
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset      = 1'b1;
    bus.valid  = 1'b0;
    bus.bit_in = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({bus.fsk_out, bus.busy, bus.phase_wrap} !== {8'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL power_on_reset: got fsk=%0d busy=%0b wrap=%0b want 0/0/0",
               bus.fsk_out, bus.busy, bus.phase_wrap);
    end
    test_reset();
    test_start_latency();
    test_bit1_tone();
    test_tone_switch();
    test_drain();
    test_rearm();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
